edge_update_scheduler: RTL

- Sits between the Avalon register front end and the arbitrage Container.
- Queues host edge-weight updates (src, dst, weight) in a FIFO. Edges are written into the Container only while it is idle.
- After each batch it pulses the Container restart and waits for container_done. Host writes therefore never collide with a running relaxation pass.

---
 rtl/edge_update_scheduler.sv | 80 ++++++++
 1 files changed

// File: rtl/edge_update_scheduler.sv
// edge_update_scheduler: queues host edge updates and writes them into the Container only between passes.
module edge_update_scheduler #(
  parameter int NODE_W   = 5,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  input  logic [NODE_W-1:0]         upd_src,
  input  logic [NODE_W-1:0]         upd_dst,
  input  logic [WEIGHT_W-1:0]       upd_weight,
  output logic                      upd_ready,
  input  logic                      run_req,
  output logic [NODE_W-1:0]         u_src,
  output logic [NODE_W-1:0]         u_dst,
  output logic [WEIGHT_W-1:0]       u_e,
  output logic                      u_we,
  output logic                      container_reset,
  input  logic                      container_done,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      overflow,
  output logic [15:0]               pass_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_n;
  logic [2*NODE_W+WEIGHT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] batch;
  logic push, pop, done_ok;
  assign upd_ready = pending != FULL;
  assign push = upd_valid && upd_ready;
  // the batch cap bounds LOAD even while the host keeps refilling the FIFO
  assign pop = state == LOAD && pending != '0 && batch < FULL;
  // container_reset is high only in the first RUN cycle, so it masks an early done
  assign done_ok = state == RUN && !container_reset && container_done;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (pending != '0 || run_req) ? LOAD : IDLE;
      LOAD:    state_n = pop ? LOAD : RUN;
      RUN:     state_n = done_ok ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {upd_src, upd_dst, upd_weight};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      batch           <= '0;
      overflow        <= 1'b0;
      u_we            <= 1'b0;
      u_src           <= '0;
      u_dst           <= '0;
      u_e             <= '0;
      container_reset <= 1'b0;
      pass_count      <= '0;
    end else begin
      pending         <= pending + (AW+1)'(push) - (AW+1)'(pop);
      wr_ptr          <= wr_ptr + AW'(push);
      rd_ptr          <= rd_ptr + AW'(pop);
      overflow        <= overflow | (upd_valid && !upd_ready);
      batch           <= state == IDLE ? '0 : batch + (AW+1)'(pop);
      u_we            <= pop;
      container_reset <= state == LOAD && !pop;
      pass_count      <= pass_count + 16'(done_ok);
      if (pop) {u_src, u_dst, u_e} <= mem[rd_ptr];
    end
  end
endmodule
